// File: rtl/select_best_hop.sv
// select_best_hop: scans the neighbour table and picks the eligible neighbour
// with the lowest qValue as next hop. A neighbour is eligible when its battery
// is at or above BAT_MIN. The block then writes this node's advertised value
// (best qValue plus HOP_COST, saturated) to MY_VALUE_ADDR.
// Memory reads take one cycle: an address driven on one edge returns data that
// is sampled on the following edge.
module select_best_hop #(
    parameter logic [15:0] HOP_COST      = 16'd1,
    parameter logic [15:0] BAT_MIN       = 16'd10,
    parameter int          MAX_NEIGHBORS = 64,
    parameter logic [15:0] MY_VALUE_ADDR = 16'h68C
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    output logic [15:0] best_neighborID,
    output logic [15:0] best_qValue,
    output logic        no_route,
    output logic        done
);

    // The counter must hold MAX_NEIGHBORS itself, not just MAX_NEIGHBORS-1.
    localparam int          CNT_W    = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [15:0] CNT_ADDR = 16'h068A;
    localparam logic [15:0] ID_BASE  = 16'h0048;
    localparam logic [15:0] BAT_BASE = 16'h0148;
    localparam logic [15:0] Q_BASE   = 16'h01C8;
    localparam logic [15:0] NONE     = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAP_CNT = 3'd1,
        S_CAP_Q   = 3'd2,
        S_EVAL    = 3'd3,
        S_CAP_ID  = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Each table entry is one 16-bit word, so entries are 2 bytes apart.
    function automatic logic [15:0] entry_addr(input logic [15:0] base,
                                               input logic [CNT_W-1:0] idx);
        return base + (16'(idx) << 1);
    endfunction

    // Clamp the stored neighbour count to the table capacity.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [15:0] raw);
        if (raw > 16'(MAX_NEIGHBORS))
            return CNT_W'(MAX_NEIGHBORS);
        return CNT_W'(raw);
    endfunction

    // The add is done at 17 bits. The result is capped at 0xFFFE, because
    // 0xFFFF is reserved to advertise "no route".
    function automatic logic [15:0] sat_hop(input logic [15:0] q);
        logic [16:0] sum;
        sum = {1'b0, q} + {1'b0, HOP_COST};
        if (sum > 17'h0FFFE)
            return 16'hFFFE;
        return sum[15:0];
    endfunction

    state_t           state_q, state_d;

    // Control and output registers.
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic             wr_q, wr_d;
    logic             done_q, done_d;
    logic             noroute_q, noroute_d;
    logic [15:0]      bid_q, bid_d;
    logic [15:0]      bq_q, bq_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] ntot_q, ntot_d;
    logic             found_q, found_d;

    // Datapath holding registers. These are only consulted once found_q
    // qualifies them.
    logic [15:0]      q_q, q_d;
    logic [15:0]      bestq_q, bestq_d;
    logic [CNT_W-1:0] bestidx_q, bestidx_d;

    // Evaluation helpers used in S_EVAL.
    logic [CNT_W-1:0] cnt_clamped;
    logic             eligible;
    logic             take;
    logic [CNT_W-1:0] n_inc;
    logic             more;
    logic             found_after;
    logic [CNT_W-1:0] id_idx;

    // Compare the current candidate against the running best.
    // Strict less-than means that on a tie the lower index wins.
    always_comb begin
        cnt_clamped = clamp_count(data_in);
        eligible    = (data_in >= BAT_MIN);
        take        = eligible && (!found_q || (q_q < bestq_q));
        n_inc       = n_q + CNT_W'(1);
        more        = (n_inc < ntot_q);
        found_after = found_q | take;
        id_idx      = take ? n_q : bestidx_q;
    end

    // State register.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_CAP_CNT;
            S_CAP_CNT:      state_d = (cnt_clamped == '0) ? S_WRITE : S_CAP_Q;
            S_CAP_Q:        state_d = S_EVAL;
            S_EVAL: begin
                if (more)
                    state_d = S_CAP_Q;
                else if (found_after)
                    state_d = S_CAP_ID;
                else
                    state_d = S_WRITE;
            end
            S_CAP_ID:       state_d = S_WRITE;
            S_WRITE:        state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs and the datapath.
    always_comb begin
        addr_d    = addr_q;
        dout_d    = dout_q;
        wr_d      = 1'b0;
        done_d    = done_q;
        noroute_d = noroute_q;
        bid_d     = bid_q;
        bq_d      = bq_q;
        n_d       = n_q;
        ntot_d    = ntot_q;
        found_d   = found_q;
        q_d       = q_q;
        bestq_d   = bestq_q;
        bestidx_d = bestidx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    noroute_d = 1'b0;
                    bid_d     = NONE;
                    bq_d      = NONE;
                    n_d       = '0;
                    found_d   = 1'b0;
                    addr_d    = CNT_ADDR;
                end
            end
            S_CAP_CNT: begin
                ntot_d = cnt_clamped;
                if (cnt_clamped == '0) begin
                    noroute_d = 1'b1;
                    addr_d    = MY_VALUE_ADDR;
                    dout_d    = NONE;
                    wr_d      = 1'b1;
                end else begin
                    addr_d = entry_addr(Q_BASE, '0);
                end
            end
            S_CAP_Q: begin
                q_d    = data_in;
                addr_d = entry_addr(BAT_BASE, n_q);
            end
            S_EVAL: begin
                if (take) begin
                    bestq_d   = q_q;
                    bestidx_d = n_q;
                    found_d   = 1'b1;
                end
                n_d = n_inc;
                if (more) begin
                    addr_d = entry_addr(Q_BASE, n_inc);
                end else if (found_after) begin
                    addr_d = entry_addr(ID_BASE, id_idx);
                end else begin
                    noroute_d = 1'b1;
                    addr_d    = MY_VALUE_ADDR;
                    dout_d    = NONE;
                    wr_d      = 1'b1;
                end
            end
            S_CAP_ID: begin
                bid_d  = data_in;
                bq_d   = bestq_q;
                addr_d = MY_VALUE_ADDR;
                dout_d = sat_hop(bestq_q);
                wr_d   = 1'b1;
            end
            S_WRITE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Control and output registers. Asynchronous reset clears any write
    // strobe immediately.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            addr_q    <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            noroute_q <= 1'b0;
            bid_q     <= NONE;
            bq_q      <= NONE;
            n_q       <= '0;
            ntot_q    <= '0;
            found_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            noroute_q <= noroute_d;
            bid_q     <= bid_d;
            bq_q      <= bq_d;
            n_q       <= n_d;
            ntot_q    <= ntot_d;
            found_q   <= found_d;
        end
    end

    // Datapath holding registers. These need no reset.
    always_ff @(posedge clock) begin
        q_q       <= q_d;
        bestq_q   <= bestq_d;
        bestidx_q <= bestidx_d;
    end

    assign address         = addr_q;
    assign wr_en           = wr_q;
    assign data_out        = dout_q;
    assign best_neighborID = bid_q;
    assign best_qValue     = bq_q;
    assign no_route        = noroute_q;
    assign done            = done_q;

endmodule

// File: tb/tb_select_best_hop.sv
// Directed bench for select_best_hop.
// The memory is behavioural: a read returns data for the current address.
// A monitor records every write and every qValue read.
module tb_select_best_hop;

    logic        clock;
    logic        nrst;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic [15:0] best_neighborID;
    logic [15:0] best_qValue;
    logic        no_route;
    logic        done;

    logic [15:0] mem [0:1023];

    int          vectors;
    int          miscompares;
    int          wr_cnt;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    int          qreads;
    logic [15:0] last_q;
    int          done_edge;

    select_best_hop dut (
        .clock          (clock),
        .nrst           (nrst),
        .start          (start),
        .data_in        (data_in),
        .address        (address),
        .wr_en          (wr_en),
        .data_out       (data_out),
        .best_neighborID(best_neighborID),
        .best_qValue    (best_qValue),
        .no_route       (no_route),
        .done           (done)
    );

    assign data_in = mem[address[10:1]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record writes and qValue-region reads, sampled at each active edge.
    always @(posedge clock) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            wr_addr = address;
            wr_data = data_out;
        end
        if (address >= 16'h01C8 && address < 16'h0600) begin
            qreads++;
            last_q = address;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    endtask

    task automatic set_count(input logic [15:0] n);
        mem[16'h068A >> 1] = n;
    endtask

    task automatic set_entry(input int n, input logic [15:0] id, input logic [15:0] bat,
                             input logic [15:0] q);
        mem[(16'h0048 >> 1) + n] = id;
        mem[(16'h0148 >> 1) + n] = bat;
        mem[(16'h01C8 >> 1) + n] = q;
    endtask

    // Start one scan, optionally pulse start again after edge pulse_edge,
    // and count edges until done rises. The wait is bounded.
    task automatic run_scan(input int pulse_edge);
        @(posedge clock); #1;
        wr_cnt = 0; qreads = 0; last_q = 16'h0; wr_addr = 16'h0; wr_data = 16'h0;
        start = 1'b1;
        @(posedge clock); #1;           // edge 0
        start = 1'b0;
        done_edge = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                done_edge = k;
                break;
            end
            if (k == pulse_edge) start = 1'b1;
        end
    endtask

    task automatic expect_scan(input string tag, input int edge_exp, input logic [15:0] id_exp,
                               input logic [15:0] q_exp, input logic nr_exp,
                               input logic [15:0] wdata_exp);
        check({tag, "/done_edge"}, done_edge, edge_exp);
        check({tag, "/best_id"}, best_neighborID, id_exp);
        check({tag, "/best_q"}, best_qValue, q_exp);
        check({tag, "/no_route"}, no_route, nr_exp);
        check({tag, "/wr_count"}, wr_cnt, 1);
        check({tag, "/wr_addr"}, wr_addr, 16'h068C);
        check({tag, "/wr_data"}, wr_data, wdata_exp);
        check({tag, "/wr_en_low"}, wr_en, 1'b0);
    endtask

    task automatic load_basic();
        clear_mem();
        set_count(16'd3);
        set_entry(0, 16'h0011, 16'd50, 16'd30);
        set_entry(1, 16'h0022, 16'd50, 16'd12);
        set_entry(2, 16'h0033, 16'd50, 16'd20);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        wr_cnt = 0; qreads = 0; last_q = 16'h0; wr_addr = 16'h0; wr_data = 16'h0;
        done_edge = -1;
        start = 1'b0;
        nrst  = 1'b1;
        clear_mem();
        #3 nrst = 1'b0;
        #1;
        check("reset/address", address, 16'h0000);
        check("reset/data_out", data_out, 16'h0000);
        check("reset/wr_en", wr_en, 1'b0);
        check("reset/done", done, 1'b0);
        check("reset/no_route", no_route, 1'b0);
        check("reset/best_id", best_neighborID, 16'hFFFF);
        check("reset/best_q", best_qValue, 16'hFFFF);
        @(posedge clock); #1 nrst = 1'b1;

        // Basic selection: lowest q is at index 1.
        load_basic();
        run_scan(-1);
        expect_scan("basic", 9, 16'h0022, 16'd12, 1'b0, 16'd13);

        // A tie resolves to the lower index; index 2 has low battery.
        clear_mem();
        set_count(16'd3);
        set_entry(0, 16'h00A1, 16'd50, 16'd5);
        set_entry(1, 16'h00A2, 16'd50, 16'd5);
        set_entry(2, 16'h00A3, 16'd9,  16'd3);
        run_scan(-1);
        expect_scan("tie", 9, 16'h00A1, 16'd5, 1'b0, 16'd6);

        // Empty table.
        clear_mem();
        set_count(16'd0);
        run_scan(-1);
        expect_scan("empty", 2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);

        // No neighbour meets the battery threshold.
        clear_mem();
        set_count(16'd2);
        set_entry(0, 16'h0005, 16'd0, 16'd4);
        set_entry(1, 16'h0006, 16'd0, 16'd2);
        run_scan(-1);
        expect_scan("all_inelig", 6, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);

        // The advertised value saturates at 0xFFFE.
        clear_mem();
        set_count(16'd1);
        set_entry(0, 16'h0077, 16'd50, 16'hFFFE);
        run_scan(-1);
        expect_scan("saturate", 5, 16'h0077, 16'hFFFE, 1'b0, 16'hFFFE);

        // A count of 200 is clamped to 64. q decreases with index, so the
        // last in-range entry (index 63) wins.
        clear_mem();
        set_count(16'd200);
        for (int n = 0; n < 64; n++)
            set_entry(n, 16'(16'h0100 + n), 16'd50, 16'(1000 - n));
        run_scan(-1);
        expect_scan("clamp", 131, 16'h013F, 16'd937, 1'b0, 16'd938);
        check("clamp/q_reads", qreads, 64);
        check("clamp/last_q_addr", last_q, 16'h0246);

        // A start pulse during the scan is ignored.
        load_basic();
        run_scan(3);
        expect_scan("midstart", 9, 16'h0022, 16'd12, 1'b0, 16'd13);

        // Reset asserted while the write strobe is high.
        load_basic();
        @(posedge clock); #1;
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clock); #1;           // edge 0
        start = 1'b0;
        repeat (8) @(posedge clock);    // edge 8: write strobe raised
        #1;
        check("abort/wr_en_before", wr_en, 1'b1);
        #1 nrst = 1'b0;
        #1;
        check("abort/wr_en", wr_en, 1'b0);
        check("abort/address", address, 16'h0000);
        check("abort/data_out", data_out, 16'h0000);
        check("abort/done", done, 1'b0);
        check("abort/no_route", no_route, 1'b0);
        check("abort/best_id", best_neighborID, 16'hFFFF);
        check("abort/best_q", best_qValue, 16'hFFFF);
        @(posedge clock); #1;
        check("abort/no_write", wr_cnt, 0);
        nrst = 1'b1;

        // The next scan after reset runs cleanly.
        run_scan(-1);
        expect_scan("after_reset", 9, 16'h0022, 16'd12, 1'b0, 16'd13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
